// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and default constants, shared by the receiver and the transmitter
`timescale 1ns/1ps
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_e;
  localparam int OS_TICKS_DEF  = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int DVSR_115200   = 53;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one-clk tick every dvsr+1 clk
// ports: clk, reset (sync, active-high), dvsr (divisor), tick (strobe)
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);
  logic [DVSR_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  // the divisor is latched at each wrap so a change never strands the counter past its limit
  always_comb begin
    tick  = cnt_q == lim_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    lim_d = tick ? dvsr : lim_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= dvsr;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver with one-deep valid/ready output register
// ports: clk, reset (sync, active-high), dvsr, rx (async serial in), rx_data/rx_valid/rx_ready
//        (output handshake), frame_err and overrun (one-clk error pulses)
`timescale 1ns/1ps
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DVSR_W    = 11,
  parameter int OS_TICKS  = OS_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DVSR_W-1:0]    dvsr,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int SW = $clog2(OS_TICKS);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID = SW'(OS_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OS_TICKS - 1);
  localparam logic [NW-1:0] N_END = NW'(DATA_BITS - 1);
  uart_state_e          state_q;
  logic                 sync1_q, rx_s_q, armed_q, done_q, tick;
  logic [1:0]           live_q;
  logic [SW-1:0]        s_cnt_q;
  logic [NW-1:0]        n_cnt_q;
  logic [DATA_BITS-1:0] sh_q, rx_data_q;
  logic                 rx_valid_q, frame_err_q, overrun_q;
  uart_baud_tick #(.DVSR_W(DVSR_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr),
    .tick  (tick)
  );
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // live_q marks when rx_s_q reflects the line rather than the synchronizer reset value;
  // armed_q requires a genuine high before a falling edge counts, so a held-low line
  // (break, or reset mid-frame) never starts a new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      live_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      sh_q        <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      live_q      <= {live_q[0], 1'b1};
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (!rx_s_q && armed_q) begin
            state_q <= START;
            s_cnt_q <= '0;
            armed_q <= 1'b0;
          end else if (rx_s_q && live_q[1]) armed_q <= 1'b1;
        START:
          if (tick) begin
            if (s_cnt_q == S_MID) begin
              state_q <= rx_s_q ? IDLE : DATA;
              s_cnt_q <= '0;
              n_cnt_q <= '0;
            end else s_cnt_q <= s_cnt_q + 1'b1;
          end
        DATA:
          if (tick) begin
            if (s_cnt_q == S_END) begin
              s_cnt_q <= '0;
              sh_q    <= {rx_s_q, sh_q[DATA_BITS-1:1]};
              n_cnt_q <= n_cnt_q + 1'b1;
              if (n_cnt_q == N_END) state_q <= STOP;
            end else s_cnt_q <= s_cnt_q + 1'b1;
          end
        STOP:
          if (tick) begin
            if (s_cnt_q == S_END) begin
              state_q     <= IDLE;
              done_q      <= rx_s_q;
              frame_err_q <= !rx_s_q;
            end else s_cnt_q <= s_cnt_q + 1'b1;
          end
      endcase
      if (done_q && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= sh_q;
        rx_valid_q <= 1'b1;
      end else if (done_q) overrun_q <= 1'b1;
      else if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core at dvsr=3 (64 clk per bit)
`timescale 1ns/1ps
module tb_uart_rx_core;
  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_ready = 1'b1;
  logic [10:0] dvsr = 11'd3;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun;
  int passed = 0, total = 0;
  int n_fe = 0, n_ov = 0, n_vh = 0;
  int b_fe, b_ov, b_vh, b_acc;
  logic [7:0] acc_q[$];
  uart_rx_core dut (
    .clk       (clk),
    .reset     (reset),
    .dvsr      (dvsr),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) n_vh++;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) hold(b[i], 64);
    hold(stop, 64);
  endtask
  task automatic snap();
    b_fe = n_fe; b_ov = n_ov; b_vh = n_vh; b_acc = acc_q.size();
  endtask
  function automatic logic [7:0] last_acc();
    return acc_q.size() == 0 ? 8'hxx : acc_q[acc_q.size() - 1];
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    reset = 1'b0;
    snap();
    hold(1'b1, 2000);
    chk("idle_vh", n_vh - b_vh, 0);
    chk("idle_fe", n_fe - b_fe, 0);
    chk("idle_ov", n_ov - b_ov, 0);
    chk("idle_acc", acc_q.size() - b_acc, 0);
    snap();
    send(8'hA5, 1'b1);
    chk("a5_cnt", acc_q.size() - b_acc, 1);
    chk("a5_data", last_acc(), 8'hA5);
    chk("a5_pulse", n_vh - b_vh, 1);
    snap();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    chk("b2b_cnt", acc_q.size() - b_acc, 2);
    chk("b2b_first", acc_q[b_acc], 8'h00);
    chk("b2b_second", last_acc(), 8'hFF);
    chk("b2b_fe", n_fe - b_fe, 0);
    rx_ready = 1'b0;
    snap();
    send(8'h3C, 1'b1);
    chk("hold_valid", rx_valid, 1);
    chk("hold_data", rx_data, 8'h3C);
    send(8'h7E, 1'b1);
    chk("ovr_pulse", n_ov - b_ov, 1);
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_clear", rx_valid, 0);
    chk("accept_cnt", acc_q.size() - b_acc, 1);
    chk("accept_data", last_acc(), 8'h3C);
    snap();
    send(8'h55, 1'b0);
    hold(1'b1, 128);
    chk("ferr_pulse", n_fe - b_fe, 1);
    chk("ferr_acc", acc_q.size() - b_acc, 0);
    chk("ferr_valid", rx_valid, 0);
    send(8'h12, 1'b1);
    chk("after_ferr_data", last_acc(), 8'h12);
    chk("after_ferr_cnt", acc_q.size() - b_acc, 1);
    snap();
    hold(1'b0, 20);
    hold(1'b1, 200);
    chk("glitch_acc", acc_q.size() - b_acc, 0);
    chk("glitch_fe", n_fe - b_fe, 0);
    chk("glitch_vh", n_vh - b_vh, 0);
    hold(1'b0, 64);
    hold(1'b1, 64);
    hold(1'b0, 64);
    hold(1'b0, 32);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    reset = 1'b0;
    snap();
    hold(1'b0, 32);
    hold(1'b0, 256);
    hold(1'b1, 64);
    hold(1'b1, 128);
    chk("mid_rst_acc", acc_q.size() - b_acc, 0);
    chk("mid_rst_fe", n_fe - b_fe, 0);
    send(8'h81, 1'b1);
    chk("resend_cnt", acc_q.size() - b_acc, 1);
    chk("resend_data", last_acc(), 8'h81);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
